// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states, default width.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } mdState_e;

    // Signed ops work on magnitudes and fix the result signs at the end.
    function automatic logic mdIsSigned(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// One iteration of the shift-add multiplier or the restoring divider on the {acc,q} pair.
module md_iter_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] accNext,
    output logic [WIDTH-1:0] qNext
);

    logic [WIDTH:0] addSum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Multiply: add multiplicand when the low multiplier bit is set, then shift {acc,q} right.
    // Divide: shift {acc,q} left one bit, keep the trial subtraction if it did not borrow.
    // Because acc always stays below the divisor, bit WIDTH of diff is a clean borrow flag.
    always_comb begin
        addSum  = {1'b0, acc} + {1'b0, operand};
        shifted = {acc, q[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        accNext = acc;
        qNext   = q;
        if (isDiv) begin
            if (!diff[WIDTH]) begin
                accNext = diff[WIDTH-1:0];
                qNext   = {q[WIDTH-2:0], 1'b1};
            end else begin
                accNext = shifted[WIDTH-1:0];
                qNext   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (q[0]) begin
                {accNext, qNext} = {addSum, q[WIDTH-1:1]};
            end else begin
                {accNext, qNext} = {1'b0, acc, q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, one bit per cycle, with pipeline stall request.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hilo_rd,
    input  logic             kill,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int            CW         = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    mdState_e         state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             isDiv_q, isDiv_d;
    logic             negRes_q, negRes_d;
    logic             negRem_q, negRem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             accept;
    logic             opSigned;
    logic             opIsDiv;
    logic [WIDTH-1:0] rsAbs;
    logic [WIDTH-1:0] rtAbs;
    logic [WIDTH-1:0] accNext;
    logic [WIDTH-1:0] qNext;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0] quoFix;
    logic [WIDTH-1:0] remFix;

    assign accept   = (state_q != MD_BUSY) & op_valid & ~kill;
    assign opSigned = mdIsSigned(op);
    assign opIsDiv  = (op == MD_DIV) || (op == MD_DIVU);
    assign rsAbs    = (opSigned & rs_data[WIDTH-1]) ? (~rs_data + 1'b1) : rs_data;
    assign rtAbs    = (opSigned & rt_data[WIDTH-1]) ? (~rt_data + 1'b1) : rt_data;

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .isDiv   (isDiv_q),
        .acc     (acc_q),
        .q       (quo_q),
        .operand (opnd_q),
        .accNext (accNext),
        .qNext   (qNext)
    );

    // Sign fix-up applied to the final iteration's result as it is committed to HI/LO.
    always_comb begin
        product = {accNext, qNext};
        prodFix = negRes_q ? (~product + 1'b1) : product;
        quoFix  = negRes_q ? (~qNext + 1'b1) : qNext;
        remFix  = negRem_q ? (~accNext + 1'b1) : accNext;
    end

    // Next-state logic: accept ops when not busy, iterate in BUSY, commit HI/LO on the last step.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        opnd_d   = opnd_q;
        isDiv_d  = isDiv_q;
        negRes_d = negRes_q;
        negRem_d = negRem_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            MD_BUSY: begin
                if (kill) begin
                    state_d = MD_IDLE;
                    count_d = '0;
                end else begin
                    acc_d   = accNext;
                    quo_d   = qNext;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_COUNT) begin
                        state_d = MD_DONE;
                        count_d = '0;
                        if (isDiv_q) begin
                            lo_d = quoFix;
                            hi_d = remFix;
                        end else begin
                            {hi_d, lo_d} = prodFix;
                        end
                    end
                end
            end
            default: begin
                state_d = MD_IDLE;
                if (accept) begin
                    if (op <= MD_DIVU) begin
                        isDiv_d  = opIsDiv;
                        negRes_d = opSigned & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        negRem_d = opSigned & rs_data[WIDTH-1];
                        count_d  = '0;
                        acc_d    = '0;
                        if (opIsDiv && (rt_data == '0)) begin
                            hi_d    = rs_data;
                            lo_d    = '1;
                            state_d = MD_DONE;
                        end else if (opIsDiv) begin
                            quo_d   = rsAbs;
                            opnd_d  = rtAbs;
                            state_d = MD_BUSY;
                        end else begin
                            quo_d   = rtAbs;
                            opnd_d  = rsAbs;
                            state_d = MD_BUSY;
                        end
                    end else if (op == MD_MTHI) begin
                        hi_d = rs_data;
                    end else if (op == MD_MTLO) begin
                        lo_d = rs_data;
                    end
                end
            end
        endcase
    end

    // State register; reset aborts any operation in flight and clears HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            opnd_q   <= '0;
            isDiv_q  <= 1'b0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            opnd_q   <= opnd_d;
            isDiv_q  <= isDiv_d;
            negRes_q <= negRes_d;
            negRem_q <= negRem_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != MD_IDLE);
    assign done  = (state_q == MD_DONE);
    assign stall = (state_q == MD_BUSY) & (op_valid | hilo_rd) & ~kill;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO pushed at issue, popped on done.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         op_valid;
    logic [2:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         hilo_rd;
    logic         kill;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    vec_t vecs[9] = '{
        '{MD_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB},
        '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
        '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD},
        '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14},
        '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
        '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
        '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
        '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF},
        '{MD_MULTU, 32'd0,        32'd12345,    32'h00000000, 32'h00000000}
    };

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .hilo_rd  (hilo_rd),
        .kill     (kill),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    // Reference model built from native SystemVerilog arithmetic.
    function automatic exp_t modelOp(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        int             sa;
        int             sbv;
        exp_t           e;
        sa  = a;
        sbv = b;
        e   = '0;
        case (o)
            MD_MULT: begin
                p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
                e = p;
            end
            MD_MULTU: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e = p;
            end
            MD_DIV: begin
                if (b == 0) e = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) e = {32'h0, 32'h80000000};
                else e = {32'(sa % sbv), 32'(sa / sbv)};
            end
            default: begin
                if (b == 0) e = {a, 32'hFFFFFFFF};
                else e = {a % b, a / b};
            end
        endcase
        return e;
    endfunction

    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        op_valid = 1'b0;
        op       = 3'd0;
        rs_data  = '0;
        rt_data  = '0;
        hilo_rd  = 1'b0;
        kill     = 1'b0;
        #1;
        total++;
        if ({hi, lo} !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset_hilo: got=%h want=0", {hi, lo});
        end
        total++;
        if ({busy, done, stall} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_flags: got=%b want=000", {busy, done, stall});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_arith();
        int   c;
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt);
            sb.push_back({vecs[i].hi, vecs[i].lo});
            waitDone(c);
            total++;
            if (c != 33) begin
                bad++;
                $display("[TB] FAIL arith%0d_latency: got=%0d want=33", i, c);
            end
            e = sb.pop_front();
            total++;
            if ({hi, lo} !== e) begin
                bad++;
                $display("[TB] FAIL arith%0d_result: got=%h want=%h", i, {hi, lo}, e);
            end
            @(negedge clk);
            total++;
            if ({busy, done} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL arith%0d_idle: busy,done got=%b want=00", i, {busy, done});
            end
        end
    endtask

    task automatic test_div_zero();
        int   c;
        exp_t e;
        applyStimulus(MD_DIVU, 32'h1234, 32'h0);
        sb.push_back({32'h1234, 32'hFFFFFFFF});
        waitDone(c);
        total++;
        if (c != 1) begin
            bad++;
            $display("[TB] FAIL divu0_latency: got=%0d want=1", c);
        end
        e = sb.pop_front();
        total++;
        if ({hi, lo} !== e) begin
            bad++;
            $display("[TB] FAIL divu0_result: got=%h want=%h", {hi, lo}, e);
        end
        applyStimulus(MD_DIV, 32'hFFFFFFF0, 32'h0);
        sb.push_back({32'hFFFFFFF0, 32'hFFFFFFFF});
        waitDone(c);
        e = sb.pop_front();
        total++;
        if (c != 1 || {hi, lo} !== e) begin
            bad++;
            $display("[TB] FAIL div0_signed: lat=%0d got=%h want lat=1 %h", c, {hi, lo}, e);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int           c;
        exp_t         e;
        logic [2:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 1000));
            if (b == 0) b = 32'd1;
            applyStimulus(o, a, b);
            sb.push_back(modelOp(o, a, b));
            waitDone(c);
            e = sb.pop_front();
            total++;
            if (c != 33 || {hi, lo} !== e) begin
                bad++;
                $display("[TB] FAIL rand%0d op=%0d rs=%h rt=%h: lat=%0d got=%h want lat=33 %h",
                         i, o, a, b, c, {hi, lo}, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mthi_kill();
        int doneCount;
        applyStimulus(MD_MTLO, 32'h55, 32'h0);
        applyStimulus(MD_MTHI, 32'hAA, 32'h0);
        total++;
        if ({hi, lo, busy, done} !== {32'hAA, 32'h55, 2'b00}) begin
            bad++;
            $display("[TB] FAIL mthi_mtlo: got hi=%h lo=%h busy,done=%b want hi=aa lo=55 busy,done=00",
                     hi, lo, {busy, done});
        end
        applyStimulus(MD_MULT, 32'h12345, 32'h6789);
        repeat (9) @(negedge clk);
        kill     = 1'b1;
        op_valid = 1'b1;
        op       = MD_MULT;
        #1;
        total++;
        if ({busy, stall} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL kill_stall: busy,stall got=%b want=10", {busy, stall});
        end
        @(posedge clk);
        #1;
        kill     = 1'b0;
        op_valid = 1'b0;
        total++;
        if ({busy, hi, lo} !== {1'b0, 32'hAA, 32'h55}) begin
            bad++;
            $display("[TB] FAIL kill_abort: got busy=%b hi=%h lo=%h want busy=0 hi=aa lo=55", busy, hi, lo);
        end
        doneCount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) doneCount++;
        end
        total++;
        if (doneCount != 0) begin
            bad++;
            $display("[TB] FAIL kill_no_done: done cycles got=%0d want=0", doneCount);
        end
    endtask

    task automatic test_ignored();
        applyStimulus(3'd6, 32'h1111, 32'h2222);
        applyStimulus(3'd7, 32'h3333, 32'h4444);
        total++;
        if ({busy, done, hi, lo} !== {2'b00, 32'hAA, 32'h55}) begin
            bad++;
            $display("[TB] FAIL ignored_op: got busy,done=%b hi=%h lo=%h want 00 aa 55", {busy, done}, hi, lo);
        end
        @(negedge clk);
        kill = 1'b1;
        op_valid = 1'b1;
        op = MD_MTHI;
        rs_data = 32'hDEAD;
        @(posedge clk);
        #1;
        kill = 1'b0;
        op_valid = 1'b0;
        total++;
        if (hi !== 32'hAA) begin
            bad++;
            $display("[TB] FAIL killed_mthi: got hi=%h want=aa", hi);
        end
    endtask

    task automatic test_back_to_back();
        int   c;
        int   stallMiss;
        bit   seen;
        exp_t e;
        applyStimulus(MD_MULT, 32'd3, 32'd5);
        sb.push_back({32'h0, 32'd15});
        @(negedge clk);
        hilo_rd = 1'b1;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hilo_rd_stall: got=%b want=1", stall);
        end
        @(posedge clk);
        #1 hilo_rd = 1'b0;
        @(negedge clk);
        op_valid = 1'b1;
        op       = MD_MULT;
        rs_data  = 32'hFFFFFFFF;
        rt_data  = 32'd9;
        sb.push_back({32'hFFFFFFFF, 32'hFFFFFFF7});
        stallMiss = 0;
        seen      = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (stall !== 1'b1) stallMiss++;
            @(negedge clk);
        end
        total++;
        if (!seen || stallMiss != 0) begin
            bad++;
            $display("[TB] FAIL b2b_stall: done seen=%0d unstalled cycles=%0d want seen=1 unstalled=0", seen, stallMiss);
        end
        e = sb.pop_front();
        total++;
        if ({hi, lo, stall} !== {e, 1'b0}) begin
            bad++;
            $display("[TB] FAIL b2b_first: got=%h stall=%b want=%h stall=0", {hi, lo}, stall, e);
        end
        @(posedge clk);
        #1 op_valid = 1'b0;
        waitDone(c);
        e = sb.pop_front();
        total++;
        if (c != 33 || {hi, lo} !== e) begin
            bad++;
            $display("[TB] FAIL b2b_second: lat=%0d got=%h want lat=33 %h", c, {hi, lo}, e);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        applyStimulus(MD_MULTU, 32'd5, 32'd6);
        repeat (5) @(negedge clk);
        op_valid = 1'b1;
        op       = MD_MULT;
        hilo_rd  = 1'b1;
        #2;
        total++;
        if ({busy, stall} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL pre_reset_busy: busy,stall got=%b want=11", {busy, stall});
        end
        reset = 1'b1;
        #1;
        total++;
        if ({hi, lo, busy, stall, done} !== {64'h0, 3'b000}) begin
            bad++;
            $display("[TB] FAIL async_reset: got hi=%h lo=%h busy,stall,done=%b want 0 0 000",
                     hi, lo, {busy, stall, done});
        end
        op_valid = 1'b0;
        hilo_rd  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_div_zero();
        test_random();
        test_mthi_kill();
        test_ignored();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
